// File: rtl/mem_pkg.sv
//============================================================================
// Module : mem_pkg -- shared funct3 encodings, FSM states, lane-mask helpers
// Rev    : 1.0
//============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_t;

    // funct3[1:0] encodes access size for every load/store variant (111 folds to D)
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = offset[0];
            2'b10:   is_misaligned = |offset[1:0];
            default: is_misaligned = |offset;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_load_align_ext.sv
//============================================================================
// Module : load_align_ext -- shifts the addressed lane down and extends it
// Rev    : 1.0
//============================================================================
`default_nettype none

module load_align_ext
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] w_shifted;

    assign w_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = w_shifted;
        case (funct3)
            F3_LB:   data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            F3_LH:   data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            F3_LBU:  data = {56'd0, w_shifted[7:0]};
            F3_LHU:  data = {48'd0, w_shifted[15:0]};
            F3_LWU:  data = {32'd0, w_shifted[31:0]};
            default: data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//============================================================================
// Module : mem_access_unit -- MEM-stage load/store unit with MEM/WB register
// Rev    : 1.0
//============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RegWrite_MEM,
    input  logic        MemtoReg_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [63:0] ALUResult_MEM,
    input  logic [63:0] write_data_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [4:0]  rd_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [63:0] dmem_rdata,
    output logic        stall_mem,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [63:0] ALUResult_WB,
    output logic [63:0] ReadData_WB,
    output logic [4:0]  rd_WB,
    output logic        misalign_WB,
    output logic        bus_error_WB
);

    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    mau_state_t  r_state;
    mau_state_t  w_state_next;
    logic [15:0] r_wait_cnt;

    logic [2:0]  w_offset;
    logic        w_mem_op;
    logic        w_misalign;
    logic        w_access;
    logic        w_timeout;
    logic        w_done;
    logic [63:0] w_load_data;

    assign w_offset   = ALUResult_MEM[2:0];
    assign w_mem_op   = MemRead_MEM | MemWrite_MEM;
    assign w_misalign = w_mem_op & is_misaligned(funct3_MEM[1:0], w_offset);
    assign w_access   = w_mem_op & ~w_misalign;
    // The final WAIT cycle gives up only if the slave is still not ready
    assign w_timeout  = (r_state == ST_WAIT) & ~dmem_ready & (r_wait_cnt == C_TIMEOUT_LAST);
    assign w_done     = w_access & dmem_ready;

    assign dmem_req   = reset_n & w_access & ~w_timeout;
    assign stall_mem  = reset_n & w_access & ~dmem_ready & ~w_timeout;
    assign dmem_we    = w_access & MemWrite_MEM & ~MemRead_MEM;
    assign dmem_addr  = {ALUResult_MEM[63:3], 3'b000};
    assign dmem_wstrb = size_mask(funct3_MEM[1:0]) << w_offset;
    assign dmem_wdata = write_data_MEM << {w_offset, 3'b000};

    load_align_ext u_load_align_ext (
        .rdata  (dmem_rdata),
        .offset (w_offset),
        .funct3 (funct3_MEM),
        .data   (w_load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= (r_state == ST_WAIT && w_state_next == ST_WAIT) ? r_wait_cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_access && !dmem_ready) w_state_next = ST_WAIT;
            ST_WAIT: if (dmem_ready || w_timeout || !w_access) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            ALUResult_WB <= 64'd0;
            ReadData_WB  <= 64'd0;
            rd_WB        <= 5'd0;
            misalign_WB  <= 1'b0;
            bus_error_WB <= 1'b0;
        end else if (stall_mem) begin
            RegWrite_WB  <= 1'b0;
            MemtoReg_WB  <= 1'b0;
            rd_WB        <= 5'd0;
            misalign_WB  <= 1'b0;
            bus_error_WB <= 1'b0;
        end else begin
            RegWrite_WB  <= RegWrite_MEM & ~w_misalign & ~w_timeout;
            MemtoReg_WB  <= MemtoReg_MEM;
            ALUResult_WB <= ALUResult_MEM;
            rd_WB        <= rd_MEM;
            misalign_WB  <= w_misalign;
            bus_error_WB <= w_timeout;
            if (w_done && MemRead_MEM) begin
                ReadData_WB <= w_load_data;
            end
        end
    end

endmodule

`default_nettype wire
